matmul_job_scheduler: RTL and testbench

Front-end controller for the matrix-multiply engine. It accepts job descriptors (A, B and C base addresses plus a tag) from `NUM_REQ` requesters and picks one with a round-robin arbiter. It configures the engine's address bases, issues a one-cycle `start_cmd`, counts result writes and watches `exec_done` with a timeout. It then returns a completion record with status to the requester that owns the job. One job is in flight at a time.

---
 rtl/matmul_sched_pkg.sv | 17 +
 rtl/matmul_job_scheduler_rr_arbiter.sv | 55 +++++
 rtl/matmul_job_scheduler.sv | 178 +++++++++++++++++
 tb/tb_matmul_job_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_sched_pkg.sv
// Shared types for the matrix-multiply job scheduler.
package matmul_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_COUNT_ERR = 2'd1,
    ST_TIMEOUT   = 2'd2
  } sched_status_t;

endpackage

// File: rtl/matmul_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts at the priority pointer, and the
// pointer moves to one past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;
  int               idx;

  // Find the first asserted request at or after the pointer, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (enable && found) grant[grant_idx] = 1'b1;
  end

  // Next pointer: one past the accepted winner, modulo NUM_REQ.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (int'(grant_idx) == NUM_REQ - 1) ptr_d = '0;
      else                                ptr_d = grant_idx + IDX_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/matmul_job_scheduler.sv
// Front-end controller for the matmul engine: arbitrates job descriptors,
// launches the engine, checks the result-write count / timeout, and returns
// a completion record to the owning requester. One job in flight at a time.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; a source holds valid and its payload stable until that edge,
// and ready never depends on the payload fields.
module matmul_job_scheduler
  import matmul_sched_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 16,
  parameter int TAG_WIDTH       = 4,
  parameter int DIM_INDEX_WIDTH = 3,
  parameter int TIMEOUT_CYCLES  = 4096,
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int CNT_W   = 2 * DIM_INDEX_WIDTH + 1,
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_a_base,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_b_base,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_c_base,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  output logic                          eng_start_cmd,
  output logic [ADDR_WIDTH-1:0]         eng_a_base,
  output logic [ADDR_WIDTH-1:0]         eng_b_base,
  output logic [ADDR_WIDTH-1:0]         eng_c_base,
  input  logic                          eng_res_write_en,
  input  logic                          eng_exec_done,
  output logic                          cmp_valid,
  input  logic                          cmp_ready,
  output logic [ID_W-1:0]               cmp_req_id,
  output logic [TAG_WIDTH-1:0]          cmp_tag,
  output logic [1:0]                    cmp_status,
  output logic                          busy,
  output logic                          hung,
  output logic [1:0]                    dbg_state
);

  // Exactly 2**(2*DIM_INDEX_WIDTH) writes make a complete result matrix.
  localparam logic [CNT_W-1:0]   EXP_WRITES = {1'b1, {(2*DIM_INDEX_WIDTH){1'b0}}};
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  sched_state_t           state_q, state_d;
  sched_status_t          status_q, status_d;
  logic [ADDR_WIDTH-1:0]  a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic                   hung_q, hung_d;

  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_idx;
  logic                   arb_enable;
  logic                   transfer;

  logic [ADDR_WIDTH-1:0]  a_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0]  b_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0]  c_arr [NUM_REQ];
  logic [TAG_WIDTH-1:0]   t_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a_base[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign b_arr[g] = req_b_base[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign c_arr[g] = req_c_base[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign t_arr[g] = req_tag[g*TAG_WIDTH +: TAG_WIDTH];
  end

  // Grants only in IDLE, never after a hang, and never while reset is held.
  assign arb_enable = (state_q == S_IDLE) && !hung_q && rst_n;
  assign transfer   = |(req_valid & grant);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .enable    (arb_enable),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Saturating write count including this cycle's strobe.
  always_comb begin
    cnt_inc = cnt_q;
    if (eng_res_write_en && (cnt_q != '1)) cnt_inc = cnt_q + CNT_W'(1);
  end

  // Next-state and job-context update.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;
    tag_d    = tag_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    hung_d   = hung_q;
    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          a_base_d = a_arr[grant_idx];
          b_base_d = b_arr[grant_idx];
          c_base_d = c_arr[grant_idx];
          tag_d    = t_arr[grant_idx];
          id_d     = grant_idx;
          cnt_d    = '0;
          timer_d  = '0;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        cnt_d   = cnt_inc;
        timer_d = timer_q + TIMER_W'(1);
        // Done takes precedence over a coincident timeout.
        if (eng_exec_done) begin
          status_d = (cnt_inc == EXP_WRITES) ? ST_OK : ST_COUNT_ERR;
          state_d  = S_REPORT;
        end else if (timer_q == TIMER_LAST) begin
          status_d = ST_TIMEOUT;
          hung_d   = 1'b1;
          state_d  = S_REPORT;
        end
      end
      S_REPORT: if (cmp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and job-context registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      tag_q    <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      hung_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      tag_q    <= tag_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      hung_q   <= hung_d;
    end
  end

  assign req_ready     = grant;
  assign eng_start_cmd = (state_q == S_LAUNCH);
  assign eng_a_base    = a_base_q;
  assign eng_b_base    = b_base_q;
  assign eng_c_base    = c_base_q;
  assign cmp_valid     = (state_q == S_REPORT);
  assign cmp_req_id    = id_q;
  assign cmp_tag       = tag_q;
  assign cmp_status    = status_q;
  assign busy          = (state_q != S_IDLE);
  assign hung          = hung_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Bench for matmul_job_scheduler: table vectors, randomized jobs against a
// round-robin/count model, reset-in-flight, and a short-timeout instance.
module tb_matmul_job_scheduler;
  import matmul_sched_pkg::*;

  localparam int AW    = 16;
  localparam int TW    = 4;
  localparam int REC_W = 7;   // {id, tag, status}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- main DUT (default timeout) ----------------
  logic [1:0]      req_valid, req_ready;
  logic [2*AW-1:0] req_a_base, req_b_base, req_c_base;
  logic [2*TW-1:0] req_tag;
  logic            eng_start_cmd, eng_res_write_en, eng_exec_done;
  logic [AW-1:0]   eng_a_base, eng_b_base, eng_c_base;
  logic            cmp_valid, cmp_ready;
  logic [0:0]      cmp_req_id;
  logic [TW-1:0]   cmp_tag;
  logic [1:0]      cmp_status, dbg_state;
  logic            busy, hung;

  matmul_job_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a_base(req_a_base), .req_b_base(req_b_base), .req_c_base(req_c_base),
    .req_tag(req_tag), .eng_start_cmd(eng_start_cmd), .eng_a_base(eng_a_base),
    .eng_b_base(eng_b_base), .eng_c_base(eng_c_base),
    .eng_res_write_en(eng_res_write_en), .eng_exec_done(eng_exec_done),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_req_id(cmp_req_id),
    .cmp_tag(cmp_tag), .cmp_status(cmp_status), .busy(busy), .hung(hung),
    .dbg_state(dbg_state)
  );

  // ---------------- timeout DUT (TIMEOUT_CYCLES = 16) ----------------
  logic [1:0]      t_req_valid, t_req_ready;
  logic [2*AW-1:0] t_req_a_base, t_req_b_base, t_req_c_base;
  logic [2*TW-1:0] t_req_tag;
  logic            t_eng_start_cmd, t_eng_res_write_en, t_eng_exec_done;
  logic [AW-1:0]   t_eng_a_base, t_eng_b_base, t_eng_c_base;
  logic            t_cmp_valid, t_cmp_ready;
  logic [0:0]      t_cmp_req_id;
  logic [TW-1:0]   t_cmp_tag;
  logic [1:0]      t_cmp_status, t_dbg_state;
  logic            t_busy, t_hung;

  matmul_job_scheduler #(.TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .rst_n(rst_n), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_a_base(t_req_a_base), .req_b_base(t_req_b_base), .req_c_base(t_req_c_base),
    .req_tag(t_req_tag), .eng_start_cmd(t_eng_start_cmd), .eng_a_base(t_eng_a_base),
    .eng_b_base(t_eng_b_base), .eng_c_base(t_eng_c_base),
    .eng_res_write_en(t_eng_res_write_en), .eng_exec_done(t_eng_exec_done),
    .cmp_valid(t_cmp_valid), .cmp_ready(t_cmp_ready), .cmp_req_id(t_cmp_req_id),
    .cmp_tag(t_cmp_tag), .cmp_status(t_cmp_status), .busy(t_busy), .hung(t_hung),
    .dbg_state(t_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [REC_W-1:0] exp_q[$];
  int rr_ptr;   // reference model priority pointer

  logic [AW-1:0] fa[2], fb[2], fc[2];
  logic [TW-1:0] ft[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_fields();
    req_a_base = {fa[1], fa[0]};
    req_b_base = {fb[1], fb[0]};
    req_c_base = {fc[1], fc[0]};
    req_tag    = {ft[1], ft[0]};
  endtask

  // Requester 0 gets the given fields; requester 1 gets them offset by 0x100 / tag+1.
  task automatic set_fields(input logic [AW-1:0] a, b, c, input logic [TW-1:0] tag);
    fa[0] = a; fb[0] = b; fc[0] = c; ft[0] = tag;
    fa[1] = a + 16'h0100; fb[1] = b + 16'h0100; fc[1] = c + 16'h0100; ft[1] = tag + 4'd1;
    drive_fields();
  endtask

  // Runs one job on the main DUT. Called with the DUT in IDLE, #1 after an edge.
  task automatic do_job(input logic [1:0] vmask, input int n_writes, input bit last_with_done,
                        input bit stray, input int hold, input int exp_id,
                        input logic [1:0] exp_status);
    logic [REC_W-1:0] rec;
    rec = '0;
    req_valid = vmask;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("grant", 32'(req_ready), 32'd1 << exp_id);
    exp_q.push_back({1'(exp_id), ft[exp_id], exp_status});
    @(posedge clk); #1;                       // transfer edge; now LAUNCH
    if (stray) eng_res_write_en = 1'b1;       // must be ignored outside RUN
    @(negedge clk);
    chk("start_cmd", 32'(eng_start_cmd), 32'd1);
    chk("launch_state", 32'(dbg_state), 32'(S_LAUNCH));
    chk("launch_a", 32'(eng_a_base), 32'(fa[exp_id]));
    chk("launch_b", 32'(eng_b_base), 32'(fb[exp_id]));
    chk("launch_c", 32'(eng_c_base), 32'(fc[exp_id]));
    chk("launch_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;                       // RUN begins
    eng_res_write_en = 1'b0;
    for (int k = 0; k < n_writes; k++) begin
      eng_res_write_en = 1'b1;
      if (last_with_done && k == n_writes - 1) eng_exec_done = 1'b1;
      if (k == 0) begin
        @(negedge clk);
        chk("start_one_cycle", 32'(eng_start_cmd), 32'd0);
      end
      @(posedge clk); #1;
    end
    eng_res_write_en = 1'b0;
    if (!last_with_done) begin
      eng_exec_done = 1'b1;
      @(posedge clk); #1;
    end
    eng_exec_done = 1'b0;
    if (stray) eng_exec_done = 1'b1;          // done outside RUN is ignored
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk("cmp_valid", 32'(cmp_valid), 32'd1);
      if (h == 0) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL scoreboard_underflow: got empty queue expected a record");
        end else rec = exp_q.pop_front();
      end
      chk("cmp_req_id", 32'(cmp_req_id), 32'(rec[6]));
      chk("cmp_tag", 32'(cmp_tag), 32'(rec[5:2]));
      chk("cmp_status", 32'(cmp_status), 32'(rec[1:0]));
      chk("report_ready", 32'(req_ready), 32'd0);
      chk("report_a_held", 32'(eng_a_base), 32'(fa[exp_id]));
      if (h == hold) cmp_ready = 1'b1;
      @(posedge clk); #1;
      eng_exec_done = 1'b0;
    end
    cmp_ready = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rr_ptr = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  vmask;
    logic [15:0] a, b, c;
    logic [3:0]  tag;
    int          n_writes;
    bit          last_with_done;
    bit          stray;
    int          hold;
    int          exp_id;
    logic [1:0]  exp_status;
  } vec_t;
  vec_t vecs[12];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int vm, win, kind, nw;
    bit lwd;

    vecs[0]  = '{2'b01, 16'h0010, 16'h0020, 16'h0030, 4'd5,  64, 1'b0, 1'b0, 0,  0, 2'd0};
    vecs[1]  = '{2'b11, 16'h1000, 16'h2000, 16'h3000, 4'd2,  64, 1'b0, 1'b0, 0,  1, 2'd0};
    vecs[2]  = '{2'b11, 16'h1100, 16'h2100, 16'h3100, 4'd7,  64, 1'b0, 1'b0, 1,  0, 2'd0};
    vecs[3]  = '{2'b11, 16'h1200, 16'h2200, 16'h3200, 4'd9,  64, 1'b0, 1'b0, 0,  1, 2'd0};
    vecs[4]  = '{2'b11, 16'h4000, 16'h5000, 16'h6000, 4'd3,  63, 1'b0, 1'b0, 0,  0, 2'd1};
    vecs[5]  = '{2'b10, 16'h4400, 16'h5400, 16'h6400, 4'd11, 64, 1'b0, 1'b0, 0,  1, 2'd0};
    vecs[6]  = '{2'b11, 16'h7000, 16'h7100, 16'h7200, 4'd14, 64, 1'b1, 1'b0, 0,  0, 2'd0};
    vecs[7]  = '{2'b01, 16'h7300, 16'h7400, 16'h7500, 4'd15, 63, 1'b1, 1'b0, 2,  0, 2'd1};
    vecs[8]  = '{2'b11, 16'h8000, 16'h9000, 16'ha000, 4'd6,  64, 1'b0, 1'b1, 10, 1, 2'd0};
    vecs[9]  = '{2'b10, 16'h8800, 16'h9800, 16'ha800, 4'd1,  65, 1'b0, 1'b0, 0,  1, 2'd1};
    vecs[10] = '{2'b01, 16'hb000, 16'hc000, 16'hd000, 4'd8,  192, 1'b0, 1'b0, 0, 0, 2'd1};
    vecs[11] = '{2'b11, 16'hb800, 16'hc800, 16'hd800, 4'd0,  0,  1'b0, 1'b0, 0,  1, 2'd1};

    req_valid = '0; eng_res_write_en = 0; eng_exec_done = 0; cmp_ready = 0;
    t_req_valid = '0; t_eng_res_write_en = 0; t_eng_exec_done = 0; t_cmp_ready = 0;
    t_req_a_base = {16'h0, 16'h1234}; t_req_b_base = {16'h0, 16'h2345};
    t_req_c_base = {16'h0, 16'h3456}; t_req_tag = {4'd0, 4'd3};
    set_fields(16'h0, 16'h0, 16'h0, 4'd0);
    req_valid = 2'b11;   // offered during reset: must not be granted
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_start", 32'(eng_start_cmd), 32'd0);
    chk("rst_a", 32'(eng_a_base), 32'd0);
    chk("rst_cmp_valid", 32'(cmp_valid), 32'd0);
    chk("rst_status", 32'(cmp_status), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hung", 32'(hung), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rr_ptr = 0;

    // Table-driven jobs
    for (int v = 0; v < 12; v++) begin
      set_fields(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].tag);
      do_job(vecs[v].vmask, vecs[v].n_writes, vecs[v].last_with_done, vecs[v].stray,
             vecs[v].hold, vecs[v].exp_id, vecs[v].exp_status);
    end

    // Randomized jobs against the reference model
    reset_dut();
    for (int j = 0; j < 12; j++) begin
      vm = int'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        fa[i] = 16'($urandom); fb[i] = 16'($urandom);
        fc[i] = 16'($urandom); ft[i] = 4'($urandom);
      end
      drive_fields();
      win = -1;
      for (int k = 0; k < 2; k++) if (win < 0 && vm[(rr_ptr + k) % 2]) win = (rr_ptr + k) % 2;
      rr_ptr = (win + 1) % 2;
      kind = int'($urandom_range(0, 3));
      nw  = (kind == 1) ? 63 : (kind == 2) ? 65 : 64;
      lwd = (kind == 3);
      do_job(2'(vm), nw, lwd, 1'b0, int'($urandom_range(0, 3)), win,
             (nw == 64) ? 2'd0 : 2'd1);
    end

    // Reset while a job is in RUN: dropped with no completion
    set_fields(16'h0aaa, 16'h0bbb, 16'h0ccc, 4'd9);
    req_valid = 2'b10;
    @(negedge clk);
    chk("mid_grant", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    eng_res_write_en = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_start", 32'(eng_start_cmd), 32'd0);
    chk("midrst_a", 32'(eng_a_base), 32'd0);
    chk("midrst_b", 32'(eng_b_base), 32'd0);
    chk("midrst_c", 32'(eng_c_base), 32'd0);
    chk("midrst_cmp_valid", 32'(cmp_valid), 32'd0);
    chk("midrst_id", 32'(cmp_req_id), 32'd0);
    chk("midrst_tag", 32'(cmp_tag), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    eng_res_write_en = 1'b0;
    req_valid = 2'b00;
    rst_n = 1'b1;
    rr_ptr = 0;
    set_fields(16'h0123, 16'h0456, 16'h0789, 4'd4);
    do_job(2'b11, 64, 1'b0, 1'b0, 0, 0, 2'd0);

    // Short-timeout instance: done on the last timer cycle wins
    t_req_valid = 2'b01;
    @(negedge clk);
    chk("t_grant0", 32'(t_req_ready), 32'd1);
    @(posedge clk); #1;
    t_req_valid = 2'b00;
    @(posedge clk); #1;                        // RUN cycle 0
    repeat (15) @(posedge clk);
    #1 t_eng_exec_done = 1'b1;                  // RUN cycle 15
    @(posedge clk); #1;
    t_eng_exec_done = 1'b0;
    @(negedge clk);
    chk("t_done_wins_valid", 32'(t_cmp_valid), 32'd1);
    chk("t_done_wins_status", 32'(t_cmp_status), 32'd1);
    chk("t_done_wins_hung", 32'(t_hung), 32'd0);
    t_cmp_ready = 1'b1;
    @(posedge clk); #1;
    t_cmp_ready = 1'b0;

    // Engine never finishes: completion 16 cycles after RUN entry
    t_req_valid = 2'b01;
    @(negedge clk);
    chk("t_grant1", 32'(t_req_ready), 32'd1);
    @(posedge clk); #1;
    t_req_valid = 2'b00;
    @(posedge clk); #1;                        // RUN cycle 0
    repeat (15) @(posedge clk);
    @(negedge clk);                            // RUN cycle 15
    chk("t_pre_timeout_valid", 32'(t_cmp_valid), 32'd0);
    chk("t_pre_timeout_hung", 32'(t_hung), 32'd0);
    @(negedge clk);                            // RUN entry + 16
    chk("t_timeout_valid", 32'(t_cmp_valid), 32'd1);
    chk("t_timeout_status", 32'(t_cmp_status), 32'd2);
    chk("t_timeout_hung", 32'(t_hung), 32'd1);
    chk("t_timeout_id", 32'(t_cmp_req_id), 32'd0);
    chk("t_timeout_tag", 32'(t_cmp_tag), 32'd3);
    t_cmp_ready = 1'b1;
    @(posedge clk); #1;
    t_cmp_ready = 1'b0;
    t_req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t_hung_no_grant", 32'(t_req_ready), 32'd0);
      chk("t_hung_idle", 32'(t_dbg_state), 32'(S_IDLE));
      chk("t_hung_sticky", 32'(t_hung), 32'd1);
    end
    t_req_valid = 2'b00;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
